status_led_array: RTL and testbench
===================================

# status_led_array

Multi-channel successor to the single-LED breathing indicator. It drives `CHANNELS` independent status LEDs from one shared free-running timebase. Each LED has its own runtime-selectable mode: off, on, breathe, blink, or blink-code, where the LED flashes N times and then pauses. The block sits at the top level beside the PLL and takes plain status inputs from the GPU core (lock, error codes, activity) to report health on the board LEDs.

## Interface
- `CHANNELS`, 4: number of LED outputs, 1..16.
- `PWM_BITS`, 5: PWM duty resolution in bits, 3..8.
- `DIV`, 1: timebase scale. Counter width is `CW = 26 + DIV`. Legal when `DIV <= 5` and `CW >= PWM_BITS + 2`. Any other value is an elaboration error.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `mode`  in  3*CHANNELS: per-channel mode. Channel i uses `mode[3i+2:3i]`.
- `code`  in  4*CHANNELS: per-channel blink-code count, 0..15. Channel i uses `code[4i+3:4i]`.
- `LED`  out  CHANNELS: LED drive, active high, registered.

## Operation
- Mode encoding: 0 OFF, 1 ON, 2 BREATHE, 3 BLINK, 4 CODE. Values 5..7 behave as OFF.
- Shared counter `cnt[CW-1:0]` increments by 1 every clk and wraps.
- Shared `step_tick` is asserted when `cnt[CW-3:0]` is all ones, so it fires once every 2^(CW-2) cycles.
- Each channel has a first-order PWM accumulator `acc[PWM_BITS:0]`:
  - Update rule: `acc <= acc[PWM_BITS-1:0] + duty`.
  - PWM bit = `acc[PWM_BITS]`.
- LED per mode:
  - OFF: LED = 0.
  - ON: LED = 1 constantly; the PWM is bypassed.
  - BREATHE: `r = cnt[CW-2 -: PWM_BITS]`. Duty = `r` when `cnt[CW-1]` = 1, else `~r`. LED = PWM bit.
  - BLINK: LED = `cnt[CW-1]`, giving a 50% square wave with period 2^CW.
  - CODE: LED = 1 in PULSE_ON, otherwise 0.
- CODE finite state machine, one per channel. States are IDLE, PULSE_ON, PULSE_OFF, GAP. All transitions happen only on `step_tick`.
  - IDLE: if mode = CODE and code != 0, latch `rem = code` and go to PULSE_ON.
  - PULSE_ON: `rem <= rem - 1`, go to PULSE_OFF.
  - PULSE_OFF: if `rem == 0`, load `gap = GAP_STEPS - 1` and go to GAP. Otherwise go to PULSE_ON.
  - GAP: if `gap == 0`, go to IDLE. Otherwise `gap <= gap - 1`.
- Resulting sequence: N on-steps interleaved with N off-steps, then GAP_STEPS gap steps, then 1 IDLE step, then repeat.
- Boundary conditions:
  - `code` changes mid-sequence: ignored until the next IDLE latch.
  - code = 0 in CODE mode: the FSM stays in IDLE and LED = 0.
  - Mode leaves CODE: the FSM returns to IDLE asynchronously to `step_tick`, on the next clk, and `rem`/`gap` are cleared.
  - Mode re-enters CODE: the sequence starts at the next `step_tick`.
  - Mode changes at the same time as `step_tick`: the new mode wins.
  - PWM accumulators run in every mode; they are cleared only by reset.

## Timing
- Reset (`reset_n` low, asynchronous) clears `cnt`, all `acc`, all FSMs (to IDLE), `rem`, `gap`, and `LED`. LED = 0 while in reset.
- Reset release: `cnt` = 0 on the first edge after release and counts from there.
- Reset asserted mid-sequence: everything aborts immediately to the reset values.
- Latency: LED[i] is a register, updated on the clk edge after the `mode`/`cnt`/FSM state that selects it. Mode → LED latency is 1 cycle for OFF/ON/BLINK, 1 cycle after the FSM state for CODE, and 1 cycle after `acc` for BREATHE.
- Inputs are assumed synchronous to `clk`. There is no internal synchroniser.
- All channels share `cnt`, so channels in the same mode are phase-aligned.

## Structure
- Package `status_led_pkg` holds:
  - `led_mode_t` (3-bit enum),
  - `code_state_t` (2-bit enum),
  - `GAP_STEPS = 4`.
- Top-level `status_led_array` holds `cnt`, `step_tick`, the BREATHE duty computation, and a generate loop over channels.
- Sub-module `status_led_channel` (one per channel) holds `acc`, the CODE FSM, `rem`/`gap`, and the LED output register. Its inputs are `clk`, `reset_n`, `mode`, `code`, `step_tick`, `blink_lvl`, and `duty`.

## Test plan
Bench configuration: `DIV = -19` (`CW = 7`), `PWM_BITS = 5`, `CHANNELS = 4`. With this, `step_tick` fires every 32 cycles and the BLINK period is 128 cycles.
- Reset: hold `reset_n` low for 10 cycles with mode = ON on all channels → LED = 0 throughout. LED = 4'hF on the 2nd edge after release.
- ON/OFF/BLINK: channels 0..2 set to OFF, ON, BLINK → LED[0] = 0 and LED[1] = 1 always. LED[2] runs 64 low / 64 high, rising 1 cycle after `cnt[6]` rises.
- BREATHE: channel 3 set to BREATHE for 256 cycles → duty-cycle count over each 32-cycle window ramps 31→0 while `cnt[6]` = 0, then 0→31 while `cnt[6]` = 1.
- CODE, code = 3: → exactly 3 high pulses of 32 cycles each, separated by 32-cycle lows, then 160 low cycles (4 gap + 1 idle steps), then repeat. Change code to 1 mid-sequence → the current burst still completes with 3 pulses, the next burst has 1.
- CODE abort: switch mode CODE→OFF during PULSE_ON → LED = 0 on the next edge and the FSM is in IDLE. Switch back → the first pulse starts at the next `step_tick`.
- Reset mid-CODE: assert `reset_n` during PULSE_ON → LED drops to 0 immediately (asynchronously). After release, the sequence restarts from IDLE.

Source files
------------

// File: rtl/status_led_pkg.sv
// Shared types and constants for the multi-channel status LED block.
// Mode and blink-code state encodings live here.
package status_led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BREATHE = 3'd2,
    MODE_BLINK   = 3'd3,
    MODE_CODE    = 3'd4
  } led_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE_ON,
    ST_PULSE_OFF,
    ST_GAP
  } code_state_t;

  localparam int GAP_STEPS = 4;
  localparam int GAP_W     = $clog2(GAP_STEPS);

endpackage

// File: rtl/status_led_array_if.sv
// Per-channel mode/code controls and LED outputs.
// The controller side drives mode/code, the LED block drives LED.
interface status_led_array_if #(
  parameter int CHANNELS = 4
);

  logic [3*CHANNELS-1:0] mode;
  logic [4*CHANNELS-1:0] code;
  logic [CHANNELS-1:0]   LED;

  modport master (
    output mode,
    output code,
    input  LED
  );

  modport slave (
    input  mode,
    input  code,
    output LED
  );

endinterface

// File: rtl/status_led_channel.sv
// One LED channel: PWM accumulator, blink-code FSM, LED register.
// Leaving CODE mode drops the FSM to IDLE on the next clock.
module status_led_channel
  import status_led_pkg::*;
#(
  parameter int PWM_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          mode,
  input  logic [3:0]          code,
  input  logic                step_tick,
  input  logic                blink_lvl,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  led_mode_t   mode_e;
  code_state_t state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PWM_BITS:0] acc_q, acc_d;
  logic        led_q, led_d;

  assign mode_e = led_mode_t'(mode);
  assign led    = led_q;

  // Blink-code sequencer: advances only on step_tick while in CODE mode.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    if (mode_e != MODE_CODE) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      gap_d   = '0;
    end else if (step_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (code != '0) begin
            rem_d   = code;
            state_d = ST_PULSE_ON;
          end
        end
        ST_PULSE_ON: begin
          rem_d   = rem_q - 4'd1;
          state_d = ST_PULSE_OFF;
        end
        ST_PULSE_OFF: begin
          if (rem_q == '0) begin
            gap_d   = GAP_W'(GAP_STEPS - 1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_PULSE_ON;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_d = ST_IDLE;
          else             gap_d   = gap_q - GAP_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // PWM accumulator runs in every mode; LED source picked by mode.
  always_comb begin
    acc_d = {1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, duty};
    led_d = 1'b0;
    case (mode_e)
      MODE_ON:      led_d = 1'b1;
      MODE_BREATHE: led_d = acc_q[PWM_BITS];
      MODE_BLINK:   led_d = blink_lvl;
      MODE_CODE:    led_d = (state_q == ST_PULSE_ON);
      default:      led_d = 1'b0;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      acc_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      acc_q   <= acc_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/status_led_array.sv
// Multi-channel status LED driver on one shared free-running timebase.
// Channels in the same mode stay phase-aligned through the shared counter.
module status_led_array
  import status_led_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 5,
  parameter int DIV      = 1
) (
  input logic              clk,
  input logic              reset_n,
  status_led_array_if.slave bus
);

  localparam int CW = 26 + DIV;

  if (DIV > 5 || CW < PWM_BITS + 2 ||
      CHANNELS < 1 || CHANNELS > 16 ||
      PWM_BITS < 3 || PWM_BITS > 8) begin : g_param_err
    $error("status_led_array: illegal parameter set");
  end

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                step_tick;
  logic                blink_lvl;
  logic [PWM_BITS-1:0] ramp;
  logic [PWM_BITS-1:0] duty;
  logic [CHANNELS-1:0] led;

  assign step_tick = &cnt_q[CW-3:0];
  assign blink_lvl = cnt_q[CW-1];
  assign ramp      = cnt_q[CW-2 -: PWM_BITS];
  assign duty      = blink_lvl ? ramp : ~ramp;
  assign bus.LED   = led;

  // Free-running timebase, wraps naturally.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
  end

  // Timebase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    status_led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .mode      (bus.mode[3*i +: 3]),
      .code      (bus.code[4*i +: 4]),
      .step_tick (step_tick),
      .blink_lvl (blink_lvl),
      .duty      (duty),
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_status_led_array.sv
// Bench for status_led_array: vector table, directed corner cases,
// random modes, all against a step-sequence reference model.
module tb_status_led_array;

  localparam int CH     = 4;
  localparam int PB     = 5;
  localparam int DIV    = -19;
  localparam int CW     = 26 + DIV;
  localparam int STEP   = 1 << (CW - 2);
  localparam int HALF   = 1 << (CW - 1);
  localparam int PERIOD = 1 << CW;
  localparam int PMAX   = 1 << PB;
  localparam int RSH    = CW - 1 - PB;
  localparam int GAPN   = 4;

  logic clk = 1'b0;
  logic reset_n;

  status_led_array_if #(.CHANNELS(CH)) bus();

  status_led_array #(
    .CHANNELS (CH),
    .PWM_BITS (PB),
    .DIV      (DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mcnt;
  int macc [CH];
  bit mact [CH];
  int mpos [CH];
  int mn   [CH];

  typedef struct {
    logic [11:0] mode;
    logic [15:0] code;
    int          n;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mcnt = 0;
    for (int i = 0; i < CH; i++) begin
      macc[i] = 0;
      mact[i] = 1'b0;
      mpos[i] = 0;
      mn[i]   = 0;
    end
  endfunction

  // Expected LED after the coming edge; then advance the model.
  function automatic logic [CH-1:0] model_edge();
    logic [CH-1:0] e;
    bit hi, tick;
    int r, duty, m, cd;
    e    = '0;
    hi   = (mcnt >= HALF);
    tick = ((mcnt % STEP) == STEP - 1);
    r    = (mcnt >> RSH) % PMAX;
    duty = hi ? r : (PMAX - 1 - r);
    for (int c = 0; c < CH; c++) begin
      m  = int'(bus.mode[3*c +: 3]);
      cd = int'(bus.code[4*c +: 4]);
      case (m)
        1: e[c] = 1'b1;
        2: e[c] = (macc[c] >= PMAX);
        3: e[c] = hi;
        4: e[c] = mact[c] && (mpos[c] < 2 * mn[c])
                  && (mpos[c] % 2 == 0);
        default: e[c] = 1'b0;
      endcase
      macc[c] = (macc[c] % PMAX) + duty;
      if (m != 4) begin
        mact[c] = 1'b0;
      end else if (tick) begin
        if (mact[c]) begin
          mpos[c]++;
          if (mpos[c] == 2 * mn[c] + GAPN) mact[c] = 1'b0;
        end else if (cd != 0) begin
          mact[c] = 1'b1;
          mpos[c] = 0;
          mn[c]   = cd;
        end
      end
    end
    mcnt = (mcnt + 1) % PERIOD;
    return e;
  endfunction

  task automatic cyc();
    logic [CH-1:0] e;
    e = model_edge();
    @(posedge clk);
    #1;
    check("model", int'(bus.LED), int'(e));
  endtask

  task automatic wait_high(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      cyc();
      if (bus.LED[0]) ok = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got 0 want 1");
    $fatal(1, "timeout");
  end

  initial begin
    int hi0, hi1, hi2, hb, hc, rise, ph, n;
    bit prev, ok;

    tbl[0] = '{12'h000, 16'h0000, 2,  4'b0000};
    tbl[1] = '{12'h249, 16'h0000, 2,  4'b1111};
    tbl[2] = '{12'h041, 16'h0000, 2,  4'b0101};
    tbl[3] = '{12'h3F5, 16'h0000, 2,  4'b1000};
    tbl[4] = '{12'h924, 16'h0000, 70, 4'b0000};
    tbl[5] = '{12'h324, 16'h0000, 40, 4'b1000};

    reset_n  = 1'b1;
    bus.mode = '0;
    bus.code = '0;
    model_reset();
    #2;
    reset_n  = 1'b0;
    bus.mode = 12'h249;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_hold", int'(bus.LED), 0);
    end
    reset_n = 1'b1;
    cyc();
    cyc();
    check("rst_rel", int'(bus.LED), 15);

    for (int i = 0; i < 6; i++) begin
      bus.mode = tbl[i].mode;
      bus.code = tbl[i].code;
      repeat (tbl[i].n) cyc();
      check("tbl", int'(bus.LED), int'(tbl[i].exp));
    end

    // OFF / ON / BLINK
    bus.mode = 12'h0C8;
    bus.code = '0;
    cyc();
    cyc();
    hi0 = 0; hi1 = 0; hi2 = 0; rise = -1;
    prev = bus.LED[2];
    for (int k = 0; k < PERIOD; k++) begin
      cyc();
      hi0 += int'(bus.LED[0]);
      hi1 += int'(bus.LED[1]);
      hi2 += int'(bus.LED[2]);
      if (!prev && bus.LED[2] && rise < 0) rise = mcnt;
      prev = bus.LED[2];
    end
    check("off_const", hi0, 0);
    check("on_const", hi1, PERIOD);
    check("blink_duty", hi2, HALF);
    check("blink_rise", rise, HALF + 1);

    // BREATHE: 128 updates of a full ramp yield 1984/32 carries
    bus.mode = 12'h400;
    repeat (8) cyc();
    hb = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cyc();
      hb += int'(bus.LED[3]);
    end
    check("breathe_carries", hb, 62);
    repeat (128) cyc();

    // CODE, 3 pulses per burst
    bus.mode = 12'h004;
    bus.code = 16'h0003;
    hc = 0;
    for (int k = 0; k < 11 * STEP; k++) begin
      cyc();
      hc += int'(bus.LED[0]);
    end
    check("code3_highs", hc, 3 * STEP);
    repeat (64) cyc();
    bus.code = 16'h0001;
    repeat (800) cyc();

    // abort CODE during a pulse, then re-enter
    wait_high(400, ok);
    check("abort_pulse_seen", int'(ok), 1);
    bus.mode = 12'h000;
    cyc();
    check("abort_led", int'(bus.LED[0]), 0);
    bus.mode = 12'h004;
    ok = 1'b0;
    ph = -1;
    for (int k = 0; k < 40 && !ok; k++) begin
      cyc();
      if (bus.LED[0]) begin
        ok = 1'b1;
        ph = mcnt % STEP;
      end
    end
    check("reentry_seen", int'(ok), 1);
    check("reentry_phase", ph, 1);

    // asynchronous reset during a pulse
    wait_high(800, ok);
    check("rst_pulse_seen", int'(ok), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst", int'(bus.LED), 0);
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold2", int'(bus.LED), 0);
    end
    reset_n = 1'b1;
    repeat (300) cyc();

    // random modes and codes
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 2) == 0)
          bus.mode[3*c +: 3] = 3'd4;
        else
          bus.mode[3*c +: 3] = 3'($urandom_range(0, 7));
        bus.code[4*c +: 4] = 4'($urandom_range(0, 15));
      end
      n = $urandom_range(1, 120);
      repeat (n) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
